alu_sequencer: RTL and testbench

Multi-cycle controller that owns a small register file and sequences the team's combinational 8-bit ALU. It accepts one command at a time over a valid/ready handshake and drives the ALU opcode and operands from registers. Shift/rotate ops iterate by a count, feeding the result back each pass. Each command ends with a result written back to the destination register and a response on a valid/ready handshake.

---
 rtl/alu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Purpose: command sequencer that owns a small register file and drives an external combinational 8-bit ALU.
// Latency: load and illegal ops respond 1 cycle after accept; ALU ops take 2; shift/rotate ops take cmd_cnt+2.
// Backpressure: one command in flight; cmd_ready is low until the response is taken, and rsp_* hold while rsp_ready is low.
module alu_sequencer #(
    parameter int NREG  = 4,
    parameter int CNT_W = 3,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic [7:0]       cmd_imm,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic [3:0]       alu_c,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [7:0]       alu_s,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_cout,
    output logic             rsp_err,
    input  logic [AW-1:0]    dbg_addr,
    output logic [7:0]       dbg_data
);

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_MIN  = 4'b0110;
    localparam logic [3:0] OP_MAX  = 4'b0111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state;
    state_t             state_n;
    logic [7:0]         rf [NREG];
    logic [CNT_W-1:0]   cnt;
    logic [AW-1:0]      rd_q;
    logic               accept;
    logic               is_load;
    logic               is_illegal;
    logic               is_shift;
    logic               last_pass;
    logic [7:0]         wb_data;
    logic               wb_cout;
    logic               rf_we;
    logic [AW-1:0]      rf_wa;
    logic [7:0]         rf_wd;

    // Held off during reset so nothing is accepted before the sequencer is live.
    assign cmd_ready  = rst_n && (state == IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign is_load    = (cmd_op == OP_LOAD);
    assign is_illegal = (cmd_op == 4'b0101) || (cmd_op == 4'b1110) || (cmd_op == 4'b1111);
    assign is_shift   = cmd_op[3];
    assign last_pass  = (state == EXEC) && (cnt == '0);
    assign rsp_valid  = (state == RESP);
    assign dbg_data   = rf[dbg_addr];

    // Final-pass result: comparator output is meaningless on equal operands, so take A; carry only for arithmetic.
    always_comb begin
        wb_data = alu_s;
        wb_cout = 1'b0;
        if (((alu_c == OP_MIN) || (alu_c == OP_MAX)) && (alu_a == alu_b)) begin
            wb_data = alu_a;
        end
        if ((alu_c >= 4'b0001) && (alu_c <= 4'b0100)) begin
            wb_cout = alu_cout;
        end
    end

    // Single register-file write port shared by load-immediate and ALU writeback.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (accept && is_load) begin
            rf_we = 1'b1;
            rf_wa = cmd_rd;
            rf_wd = cmd_imm;
        end else if (last_pass) begin
            rf_we = 1'b1;
            rf_wa = rd_q;
            rf_wd = wb_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: load/illegal skip EXEC; EXEC exits when the pass counter is exhausted.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (is_load || is_illegal) ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Register file; reset clears every entry so an aborted command leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= 8'h00;
            end
        end else if (rf_we) begin
            rf[rf_wa] <= rf_wd;
        end
    end

    // ALU operand/opcode registers, pass counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_c    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            cnt      <= '0;
            rd_q     <= '0;
            rsp_data <= '0;
            rsp_cout <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            if (is_load) begin
                rsp_data <= cmd_imm;
                rsp_cout <= 1'b0;
                rsp_err  <= 1'b0;
            end else if (is_illegal) begin
                rsp_data <= 8'h00;
                rsp_cout <= 1'b0;
                rsp_err  <= 1'b1;
            end else begin
                alu_c <= cmd_op;
                alu_a <= rf[cmd_ra];
                alu_b <= rf[cmd_rb];
                cnt   <= is_shift ? cmd_cnt : '0;
                rd_q  <= cmd_rd;
            end
        end else if (state == EXEC) begin
            if (cnt != '0) begin
                alu_a <= alu_s;
                cnt   <= cnt - CNT_W'(1);
            end else begin
                rsp_data <= wb_data;
                rsp_cout <= wb_cout;
                rsp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Purpose: randomized and directed check of alu_sequencer against an arithmetic reference model.
// Latency: expects 1 cycle for load/illegal, 2 for ALU ops, cnt+2 for shift/rotate.
// Backpressure: holds rsp_ready low for a chosen number of cycles and checks the response is frozen.
module tb_alu_sequencer;

    localparam int NREG  = 4;
    localparam int CNT_W = 3;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [AW-1:0]    cmd_rd;
    logic [AW-1:0]    cmd_ra;
    logic [AW-1:0]    cmd_rb;
    logic [7:0]       cmd_imm;
    logic [CNT_W-1:0] cmd_cnt;
    logic [3:0]       alu_c;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [7:0]       alu_s;
    logic             alu_cout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic             rsp_cout;
    logic             rsp_err;
    logic [AW-1:0]    dbg_addr;
    logic [7:0]       dbg_data;

    int   nvec = 0;
    int   nerr = 0;
    logic [7:0] m_rf [NREG];

    always #5 clk = ~clk;

    alu_sequencer #(.NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_imm(cmd_imm), .cmd_cnt(cmd_cnt),
        .alu_c(alu_c), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s(alu_s), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Stand-in for the team ALU: one step per evaluation; comparator yields junk on equal operands.
    always_comb begin
        logic [8:0] t;
        t        = '0;
        alu_s    = 8'h00;
        alu_cout = 1'b0;
        case (alu_c)
            4'd1: begin t = {1'b0, alu_a} + {1'b0, alu_b}; alu_s = t[7:0]; alu_cout = t[8]; end
            4'd2: alu_s = alu_a & alu_b;
            4'd3: begin t = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1; alu_s = t[7:0]; alu_cout = t[8]; end
            4'd4: begin t = {1'b0, alu_a} + 9'd1; alu_s = t[7:0]; alu_cout = t[8]; end
            4'd6: alu_s = (alu_a == alu_b) ? 8'hEE : (($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b);
            4'd7: alu_s = (alu_a == alu_b) ? 8'hEE : (($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b);
            4'd8: begin alu_s = {alu_a[0], alu_a[7:1]}; alu_cout = alu_a[0]; end
            4'd9: begin alu_s = {alu_a[6:0], alu_a[7]}; alu_cout = alu_a[7]; end
            4'd10: begin alu_s = {1'b0, alu_a[7:1]}; alu_cout = alu_a[0]; end
            4'd11: begin alu_s = {alu_a[6:0], 1'b0}; alu_cout = alu_a[7]; end
            4'd12: begin alu_s = {alu_a[7], alu_a[7:1]}; alu_cout = alu_a[0]; end
            4'd13: begin alu_s = ~alu_a; alu_cout = 1'b1; end
            default: begin alu_s = 8'hA5; alu_cout = 1'b1; end
        endcase
    end

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Value after k passes of a shift/rotate op, computed in one arithmetic step.
    function automatic logic [7:0] shift_k(input logic [3:0] op, input logic [7:0] a, input int k);
        int ua, sa, m, r;
        ua = a;
        sa = $signed(a);
        m  = k % 8;
        case (op)
            4'd8:    r = (ua >> m) | (ua << (8 - m));
            4'd9:    r = (ua << m) | (ua >> (8 - m));
            4'd10:   r = ua >> k;
            4'd11:   r = ua << k;
            4'd12:   r = sa >>> k;
            4'd13:   r = ((k % 2) == 1) ? ~ua : ua;
            default: r = ua;
        endcase
        return 8'(r);
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREG; i++) begin
            dbg_addr = AW'(i);
            #1;
            check(tag, dbg_data, m_rf[i]);
        end
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                          input logic [AW-1:0] rb, input logic [7:0] imm, input logic [CNT_W-1:0] cnt,
                          input int hold);
        logic [7:0] a, b, edata, d0;
        logic       ecout, eerr;
        int         elat, lat, t, s;
        a = m_rf[ra];
        b = m_rf[rb];
        edata = 8'h00; ecout = 1'b0; eerr = 1'b0; elat = 2;
        case (op)
            4'd0: begin edata = imm; elat = 1; end
            4'd1: begin s = int'(a) + int'(b); edata = 8'(s); ecout = (s > 255); end
            4'd2: edata = a & b;
            4'd3: begin edata = 8'(int'(a) - int'(b)); ecout = (a >= b); end
            4'd4: begin edata = 8'(int'(a) + 1); ecout = (a == 8'hFF); end
            4'd6: edata = ($signed(a) <= $signed(b)) ? a : b;
            4'd7: edata = ($signed(a) >= $signed(b)) ? a : b;
            4'd5, 4'd14, 4'd15: begin eerr = 1'b1; elat = 1; end
            default: begin edata = shift_k(op, a, int'(cnt) + 1); elat = int'(cnt) + 2; end
        endcase

        @(negedge clk);
        cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm; cmd_cnt = cnt;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", int'(t < 20), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = $urandom_range(0, 15);
        cmd_ra = AW'($urandom); cmd_rb = AW'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            check("exec_alu_c", alu_c, op);
            check("exec_alu_a", alu_a, op[3] ? shift_k(op, a, lat - 1) : a);
            check("exec_alu_b", alu_b, b);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, elat);
        check("rsp_data", rsp_data, edata);
        check("rsp_cout", rsp_cout, ecout);
        check("rsp_err", rsp_err, eerr);
        if (!eerr) m_rf[rd] = edata;
        check_regs("regfile");

        d0 = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, d0);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        int t;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0; cmd_imm = '0; cmd_cnt = '0; dbg_addr = '0;
        for (int i = 0; i < NREG; i++) m_rf[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_c", alu_c, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_cout", rsp_cout, 0);
        check("rst_rsp_err", rsp_err, 0);
        check_regs("rst_regfile");
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", cmd_ready, 1);

        // Basic add, carry out, subtract.
        do_cmd(4'd0, 2'd0, 2'd0, 2'd0, 8'h05, 3'd0, 0);
        do_cmd(4'd0, 2'd1, 2'd0, 2'd0, 8'h03, 3'd0, 0);
        do_cmd(4'd1, 2'd2, 2'd0, 2'd1, 8'h00, 3'd0, 0);
        do_cmd(4'd0, 2'd0, 2'd0, 2'd0, 8'hFF, 3'd0, 0);
        do_cmd(4'd0, 2'd1, 2'd0, 2'd0, 8'h01, 3'd0, 0);
        do_cmd(4'd1, 2'd3, 2'd0, 2'd1, 8'h00, 3'd0, 0);
        do_cmd(4'd3, 2'd2, 2'd1, 2'd0, 8'h00, 3'd0, 0);
        // Rotate right three passes.
        do_cmd(4'd0, 2'd0, 2'd0, 2'd0, 8'h81, 3'd0, 0);
        do_cmd(4'd8, 2'd0, 2'd0, 2'd0, 8'h00, 3'd2, 0);
        // Signed min/max, including equal operands.
        do_cmd(4'd0, 2'd0, 2'd0, 2'd0, 8'h80, 3'd0, 0);
        do_cmd(4'd0, 2'd1, 2'd0, 2'd0, 8'h01, 3'd0, 0);
        do_cmd(4'd6, 2'd2, 2'd0, 2'd1, 8'h00, 3'd0, 0);
        do_cmd(4'd7, 2'd3, 2'd0, 2'd1, 8'h00, 3'd0, 0);
        do_cmd(4'd0, 2'd0, 2'd0, 2'd0, 8'h42, 3'd0, 0);
        do_cmd(4'd0, 2'd1, 2'd0, 2'd0, 8'h42, 3'd0, 0);
        do_cmd(4'd6, 2'd2, 2'd0, 2'd1, 8'h00, 3'd0, 0);
        do_cmd(4'd7, 2'd3, 2'd0, 2'd1, 8'h00, 3'd0, 0);
        // Response backpressure and illegal opcodes.
        do_cmd(4'd1, 2'd0, 2'd0, 2'd0, 8'h00, 3'd0, 5);
        do_cmd(4'd5, 2'd1, 2'd0, 2'd0, 8'h00, 3'd0, 2);
        do_cmd(4'd14, 2'd2, 2'd0, 2'd0, 8'h00, 3'd0, 0);
        do_cmd(4'd15, 2'd3, 2'd0, 2'd0, 8'h00, 3'd0, 0);

        // Reset during the second pass of a 5-pass rotate.
        do_cmd(4'd0, 2'd3, 2'd0, 2'd0, 8'h77, 3'd0, 0);
        @(negedge clk);
        cmd_op = 4'd8; cmd_rd = 2'd3; cmd_ra = 2'd3; cmd_rb = 2'd0; cmd_cnt = 3'd4; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_pass0_alu_a", alu_a, 8'h77);
        @(negedge clk);
        check("abort_pass1_alu_a", alu_a, 8'hBB);
        rst_n = 1'b0;
        for (int i = 0; i < NREG; i++) m_rf[i] = 8'h00;
        #1;
        check("abort_cmd_ready", cmd_ready, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_alu_c", alu_c, 0);
        check("abort_alu_a", alu_a, 0);
        check("abort_alu_b", alu_b, 0);
        check("abort_rsp_data", rsp_data, 0);
        check("abort_rsp_err", rsp_err, 0);
        check_regs("abort_regfile");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_rel_ready", cmd_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 0);
        end

        // Random traffic.
        for (int n = 0; n < 250; n++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            do_cmd(op, AW'($urandom), AW'($urandom), AW'($urandom), 8'($urandom),
                   CNT_W'($urandom), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
